// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  // Default width of one channel word.
  localparam int DEFAULT_DATA_W = 16;

  // Channel tags carried on the word-select pin.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Deserializer states.
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    PAD       = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_deserializer_sync_rise_det.sv
// N-flop synchronizer for an asynchronous clock-like pin, with a registered
// single-cycle pulse on every synchronized 0->1 transition.
module sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              q_prev;
  logic              q;

  assign q = sync_q[STAGES-1];

  // Synchronizer chain; bit 0 absorbs metastability.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  // Edge detector on the synchronized level, registered for clean timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      q_prev <= q;
      rise   <= q & ~q_prev;
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples sclk / l_r_clk / sdata in the clk domain and
// recovers MSB-first signed words with a one-cycle strobe and channel tag.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     l_r_clk,
  input  logic                     sdata,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     sample_ch,
  output logic                     frame_lr,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // Pin synchronizers and bit-clock rise detection.
  logic                   rise;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   lr_s;
  logic                   sd_s;

  sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_sclk_det (
    .clk   (clk),
    .reset (reset),
    .d     (sclk),
    .rise  (rise)
  );

  // Word-select and data synchronizers, plus one flop so lr_s/sd_s line up
  // with the registered rise pulse and reflect the pins at the sclk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lr_sync <= '0;
      sd_sync <= '0;
      lr_s    <= 1'b0;
      sd_s    <= 1'b0;
    end else begin
      lr_sync <= {lr_sync[SYNC_STAGES-2:0], l_r_clk};
      sd_sync <= {sd_sync[SYNC_STAGES-2:0], sdata};
      lr_s    <= lr_sync[SYNC_STAGES-1];
      sd_s    <= sd_sync[SYNC_STAGES-1];
    end
  end

  // Deserializer state. shreg holds the first DATA_W-1 bits of a word;
  // the final bit is appended straight from sd_s when the word completes.
  rx_state_t          state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-2:0]  shreg;
  logic               cur_ch;
  logic               lr_last;
  logic               primed;
  logic               boundary;
  logic [DATA_W-1:0]  word_next;

  // The level seen at the first rise after reset is only a reference, so
  // joining mid-word never fabricates a boundary and a partial word.
  assign boundary  = primed && (lr_s != lr_last);
  assign word_next = {shreg, sd_s};
  assign frame_lr  = sample_ch;

  // Shift register for incoming data bits.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath register with no reset; it is always refilled
    // from a boundary before its contents are used.
    if (rise && !boundary && state == SHIFT) begin
      shreg <= word_next[DATA_W-2:0];
    end
  end

  // Framing FSM and output registers, advanced only on bit-clock rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      bit_cnt      <= '0;
      cur_ch       <= CH_LEFT;
      lr_last      <= 1'b0;
      primed       <= 1'b0;
      sample_out   <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= CH_LEFT;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        lr_last <= lr_s;
        primed  <= 1'b1;
        if (boundary) begin
          // Boundary rise is the one-bit delay slot; its data is ignored.
          frame_err <= (state == SHIFT);
          state     <= SHIFT;
          bit_cnt   <= '0;
          cur_ch    <= lr_s;
        end else if (state == SHIFT) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state        <= PAD;
            sample_valid <= 1'b1;
            sample_out   <= word_next;
            sample_ch    <= cur_ch;
            if (cur_ch == CH_RIGHT) right_out <= word_next;
            else                    left_out  <= word_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer with a slot-level reference model.
module tb_i2s_rx_deserializer;

  localparam int DATA_W = 16;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 2;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        sclk    = 1'b0;
  logic        l_r_clk = 1'b0;
  logic        sdata   = 1'b0;
  logic [15:0] sample_out;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        sample_valid;
  logic        sample_ch;
  logic        frame_lr;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic first_ch_seen = 1'b0;
  logic first_ch      = 1'b1;

  typedef struct {
    int          rise_cyc;
    logic [15:0] word;
    logic        ch;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  logic [15:0] exp_left  = '0;
  logic [15:0] exp_right = '0;

  // Reference model state: one slot at a time, bits collected in a queue.
  bit   m_primed  = 1'b0;
  bit   m_entered = 1'b0;
  bit   m_lr_last = 1'b0;
  bit   m_ch      = 1'b0;
  bit   seg[$];

  i2s_rx_deserializer #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .l_r_clk      (l_r_clk),
    .sdata        (sdata),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .frame_lr     (frame_lr),
    .left_out     (left_out),
    .right_out    (right_out),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A slot is the word-select level between changes: the change rise is the
  // delay slot, the next DATA_W rises are the word, anything after is padding.
  function automatic void model_rise(input logic lr, input logic d);
    logic [15:0] w;
    if (!m_primed) begin
      m_primed  = 1'b1;
      m_lr_last = lr;
      return;
    end
    if (lr != m_lr_last) begin
      if (m_entered && seg.size() < DATA_W) err_q.push_back(cyc);
      m_entered = 1'b1;
      m_ch      = lr;
      m_lr_last = lr;
      seg.delete();
    end else if (m_entered && seg.size() < DATA_W) begin
      seg.push_back(d);
      if (seg.size() == DATA_W) begin
        w = '0;
        foreach (seg[i]) w = 16'(w * 2 + 16'(seg[i]));
        exp_q.push_back('{cyc, w, m_ch});
      end
    end
  endfunction

  // One sclk period: pins change in the low phase, rise after 4 clk cycles.
  task automatic send_rise(input logic lr, input logic d);
    sclk    = 1'b0;
    l_r_clk = lr;
    sdata   = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    if (!reset) model_rise(lr, d);
    repeat (4) @(negedge clk);
  endtask

  // slot = total rises at this word-select level (delay slot + data + pad).
  task automatic send_word(input logic ch, input logic [15:0] word, input int slot);
    send_rise(ch, 1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) send_rise(ch, word[i]);
    for (int i = 0; i < slot - 1 - DATA_W; i++) send_rise(ch, 1'b0);
  endtask

  task automatic send_partial(input logic ch, input logic [15:0] word, input int nbits);
    send_rise(ch, 1'b0);
    for (int i = 0; i < nbits; i++) send_rise(ch, word[DATA_W-1-i]);
  endtask

  task automatic do_reset(input int n);
    sclk      = 1'b0;
    reset     = 1'b1;
    m_primed  = 1'b0;
    m_entered = 1'b0;
    seg.delete();
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    sclk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    exp_t e;
    int   ec;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        err_q.delete();
        exp_left  = '0;
        exp_right = '0;
        check("rst_sample_out", 32'(sample_out), 32'(exp_left));
        check("rst_left_out", 32'(left_out), 32'(exp_left));
        check("rst_right_out", 32'(right_out), 32'(exp_right));
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_sample_ch", 32'(sample_ch), 0);
        check("rst_frame_lr", 32'(frame_lr), 0);
        continue;
      end
      check("valid_err_exclusive", 32'(sample_valid & frame_err), 0);
      if (sample_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(sample_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("valid_latency", 32'(cyc - e.rise_cyc), 32'(LAT));
          check("sample_out", 32'(sample_out), 32'(e.word));
          check("sample_ch", 32'(sample_ch), 32'(e.ch));
          check("frame_lr", 32'(frame_lr), 32'(e.ch));
          if (e.ch) exp_right = e.word;
          else      exp_left  = e.word;
          if (!first_ch_seen) begin
            first_ch_seen = 1'b1;
            first_ch      = sample_ch;
          end
        end
      end
      if (frame_err) begin
        n_err++;
        if (err_q.size() == 0) begin
          check("unexpected_frame_err", 32'(frame_err), 0);
        end else begin
          ec = err_q.pop_front();
          check("err_latency", 32'(cyc - ec), 32'(LAT));
        end
      end
      while (exp_q.size() > 0 && cyc - exp_q[0].rise_cyc > LAT) begin
        check("missed_valid", 32'(cyc - exp_q[0].rise_cyc), 32'(LAT));
        void'(exp_q.pop_front());
      end
      while (err_q.size() > 0 && cyc - err_q[0] > LAT) begin
        check("missed_frame_err", 32'(cyc - err_q[0]), 32'(LAT));
        void'(err_q.pop_front());
      end
      check("left_out", 32'(left_out), 32'(exp_left));
      check("right_out", 32'(right_out), 32'(exp_right));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int v0;
    repeat (3) @(negedge clk);

    // Startup: reset held across the start of a right word, released mid-word.
    for (int i = 0; i < 8; i++) send_rise(1'b1, i[0]);
    reset = 1'b0;
    for (int i = 8; i < 32; i++) send_rise(1'b1, ~i[0]);

    // Standard frames: 32-bit slots.
    repeat (2) begin
      send_word(1'b0, 16'h8001, 32);
      send_word(1'b1, 16'h7FFE, 32);
    end
    settle();
    check("std_valid_count", 32'(n_valid), 4);
    check("std_first_ch_left", 32'(first_ch), 0);
    check("std_left_out", 32'(left_out), 32'h8001);
    check("std_right_out", 32'(right_out), 32'h7FFE);
    check("std_frame_lr_right", 32'(frame_lr), 1);
    check("std_no_err", 32'(n_err), 0);

    // Truncation: left word cut after 10 data bits.
    send_partial(1'b0, 16'hFFFF, 10);
    send_word(1'b1, 16'h1357, 32);
    settle();
    check("trunc_err_count", 32'(n_err), 1);
    check("trunc_left_kept", 32'(left_out), 32'h8001);
    check("trunc_next_right", 32'(right_out), 32'h1357);
    send_word(1'b0, 16'h2468, 32);
    settle();
    check("trunc_next_left", 32'(left_out), 32'h2468);

    // Tight slots: delay slot plus DATA_W data rises, no padding.
    v0 = n_valid;
    repeat (2) begin
      send_word(1'b1, 16'hABCD, 17);
      send_word(1'b0, 16'h1234, 17);
    end
    settle();
    check("tight_valid_count", 32'(n_valid - v0), 4);
    check("tight_no_err", 32'(n_err), 1);
    check("tight_left_out", 32'(left_out), 32'h1234);
    check("tight_right_out", 32'(right_out), 32'hABCD);

    // Reset mid-stream during SHIFT of a right word.
    send_partial(1'b1, 16'h5A5A, 7);
    do_reset(2);
    check("mid_rst_sample_out", 32'(sample_out), 0);
    check("mid_rst_left_out", 32'(left_out), 0);
    check("mid_rst_right_out", 32'(right_out), 0);
    v0 = n_valid;
    for (int i = 0; i < 20; i++) send_rise(1'b1, i[1]);
    check("mid_rst_no_valid_before_boundary", 32'(n_valid - v0), 0);
    send_word(1'b0, 16'h0F0F, 32);
    settle();
    check("mid_rst_valid_count", 32'(n_valid - v0), 1);
    check("mid_rst_left_out", 32'(left_out), 32'h0F0F);
    check("mid_rst_right_zero", 32'(right_out), 0);

    settle();
    check("pending_words", 32'(exp_q.size()), 0);
    check("pending_errs", 32'(err_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
